// File: rtl/accel_apb_map_pkg.sv
// Register map, FSM state type and strobe constants
// shared by the image loader APB requester.
package accel_apb_map_pkg;

    localparam logic [9:0] IDX_IMG_BASE     = 10'd10;
    localparam logic [9:0] IDX_IMG_CMD      = 10'd42;
    localparam logic [9:0] IDX_RESULT       = 10'd43;
    localparam logic [9:0] IDX_WCMD         = 10'd44;
    localparam logic [9:0] IDX_MODEL_PARAMS = 10'd45;

    localparam logic [3:0] PSTRB_WR = 4'hF;
    localparam logic [3:0] PSTRB_RD = 4'h0;

    localparam int WORD_CNT_W = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_WAIT,
        ST_LOAD_SETUP,
        ST_LOAD_ACCESS,
        ST_CMD_SETUP,
        ST_CMD_ACCESS,
        ST_POLL_SETUP,
        ST_POLL_ACCESS,
        ST_POLL_GAP
    } ldr_state_t;

endpackage

// File: rtl/apb_xfer_engine.sv
// Single APB SETUP/ACCESS transfer engine; a req pulse
// loads the bus signals and starts the SETUP phase.
module apb_xfer_engine
    import accel_apb_map_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        req,
    input  logic [9:0]  addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        slverr,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [9:0]  PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    assign ack    = PSEL & PENABLE & PREADY;
    assign rdata  = PRDATA;
    assign slverr = ack & PSLVERR;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PSTRB   <= '0;
        end else if (req) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= addr;
            PWRITE  <= wr;
            PWDATA  <= wdata;
            PSTRB   <= wr ? PSTRB_WR : PSTRB_RD;
        end else if (PSEL && !PENABLE) begin
            PENABLE <= 1'b1;
        end else if (ack) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end
    end

endmodule

// File: rtl/apb_img_loader_master.sv
// Streams an image frame into the accelerator over APB, triggers it and polls
// for the result. APB_LOADER_POLL_TIMEOUT_EN bounds the number of poll reads.
module apb_img_loader_master
    import accel_apb_map_pkg::*;
#(
    parameter int IMG_BASE_IDX     = int'(IDX_IMG_BASE),
    parameter int NUM_WORDS        = 32,
    parameter int IMG_CMD_IDX      = int'(IDX_IMG_CMD),
    parameter int RESULT_IDX       = int'(IDX_RESULT),
    parameter int RESULT_VALID_BIT = 31,
    parameter int POLL_GAP         = 4
`ifdef APB_LOADER_POLL_TIMEOUT_EN
    ,
    parameter int MAX_POLLS        = 1024
`endif
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [9:0]  PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic        start,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        err
);

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD =
        WORD_CNT_W'(NUM_WORDS - 1);

    ldr_state_t state, state_nxt;

    logic [WORD_CNT_W-1:0] word_cnt;
    logic [7:0]            gap_cnt;
    logic [9:0]            load_addr;

    logic        req, x_wr, ack, slverr;
    logic [9:0]  x_addr;
    logic [31:0] x_wdata, rdata;

    logic go_load, go_cmd, go_poll;
    logic fin_ok, fin_err;
    logic last_word, res_valid, timeout;

    assign load_addr = 10'(IMG_BASE_IDX) + 10'(word_cnt);
    assign last_word = (word_cnt == LAST_WORD);
    assign res_valid = rdata[RESULT_VALID_BIT];
    assign busy      = (state != ST_IDLE);

`ifdef APB_LOADER_POLL_TIMEOUT_EN
    localparam int PCW = $clog2(MAX_POLLS + 1);

    logic [PCW-1:0] poll_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            poll_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            poll_cnt <= '0;
        end else if (state == ST_POLL_ACCESS && ack && !slverr) begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    assign timeout = (poll_cnt == PCW'(MAX_POLLS - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        go_load   = 1'b0;
        go_cmd    = 1'b0;
        go_poll   = 1'b0;
        fin_ok    = 1'b0;
        fin_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (s_valid && s_ready) begin
                    state_nxt = ST_LOAD_SETUP;
                    go_load   = 1'b1;
                end
            end
            ST_LOAD_SETUP: state_nxt = ST_LOAD_ACCESS;
            ST_LOAD_ACCESS: begin
                if (ack) begin
                    if (slverr) begin
                        fin_err = 1'b1;
                    end else if (last_word) begin
                        state_nxt = ST_CMD_SETUP;
                        go_cmd    = 1'b1;
                    end else begin
                        state_nxt = ST_LOAD_WAIT;
                    end
                end
            end
            ST_CMD_SETUP: state_nxt = ST_CMD_ACCESS;
            ST_CMD_ACCESS: begin
                if (ack) begin
                    if (slverr) begin
                        fin_err = 1'b1;
                    end else begin
                        state_nxt = ST_POLL_SETUP;
                        go_poll   = 1'b1;
                    end
                end
            end
            ST_POLL_SETUP: state_nxt = ST_POLL_ACCESS;
            ST_POLL_ACCESS: begin
                if (ack) begin
                    if (slverr || (!res_valid && timeout)) begin
                        fin_err = 1'b1;
                    end else if (res_valid) begin
                        fin_ok = 1'b1;
                    end else if (POLL_GAP == 0) begin
                        state_nxt = ST_POLL_SETUP;
                        go_poll   = 1'b1;
                    end else begin
                        state_nxt = ST_POLL_GAP;
                    end
                end
            end
            ST_POLL_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_POLL_SETUP;
                    go_poll   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (fin_ok || fin_err) state_nxt = ST_IDLE;
    end

    // Reads default to the result register with zero write data
    always_comb begin
        req     = go_load | go_cmd | go_poll;
        x_addr  = 10'(RESULT_IDX);
        x_wr    = 1'b0;
        x_wdata = '0;
        unique case (1'b1)
            go_load: begin
                x_addr  = load_addr;
                x_wr    = 1'b1;
                x_wdata = s_data;
            end
            go_cmd: begin
                x_addr  = 10'(IMG_CMD_IDX);
                x_wr    = 1'b1;
                x_wdata = 32'h1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            s_ready  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            word_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            s_ready <= (state_nxt == ST_LOAD_WAIT);
            done    <= fin_ok | fin_err;
            if (state == ST_IDLE && start) begin
                word_cnt <= '0;
                err      <= 1'b0;
            end else if (state == ST_LOAD_ACCESS && ack && !slverr) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (fin_err) err <= 1'b1;
            if (fin_ok) result <= rdata;
            gap_cnt <= (state == ST_POLL_GAP) ? gap_cnt + 8'd1 : 8'd0;
        end
    end

    apb_xfer_engine u_xfer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .req     (req),
        .addr    (x_addr),
        .wr      (x_wr),
        .wdata   (x_wdata),
        .ack     (ack),
        .rdata   (rdata),
        .slverr  (slverr),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

endmodule

// File: tb/tb_apb_img_loader_master.sv
// Bench for apb_img_loader_master: randomized frames against an
// APB slave model and a transaction-list reference.
module tb_apb_img_loader_master;

    localparam int NW       = 32;
    localparam int PG       = 4;
    localparam int MP       = 8;
    localparam int IMG_BASE = 10;
    localparam int CMD      = 42;
    localparam int RES      = 43;
    localparam int LIMIT    = 5000;

    typedef struct packed {
        logic [9:0]  a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  s;
    } xact_t;

    logic        PCLK, PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic        PREADY, PSLVERR;
    logic        start, s_valid, s_ready, busy, done, err;
    logic [31:0] s_data, result;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_g   = 0;

    int wait_max, wait_word, wait_n, n_inv, err_word, rd_k, last_rd;
    bit seen_read, prev_setup, frame_over;
    int wl;
    logic [31:0] res_val, exp_result;
    xact_t cap;
    xact_t log_q[$];
    xact_t exp_q[$];

    apb_img_loader_master #(
        .NUM_WORDS (NW),
        .POLL_GAP  (PG)
`ifdef APB_LOADER_POLL_TIMEOUT_EN
        ,
        .MAX_POLLS (MP)
`endif
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial forever begin
        @(posedge PCLK);
        cyc_g++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // APB slave: random wait states, poll answers, optional PSLVERR
    initial begin
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        wl = 0; prev_setup = 0;
        forever begin
            @(negedge PCLK);
            PREADY = 1'b0;
            PSLVERR = 1'b0;
            if (!PRESETn) begin
                prev_setup = 0;
                continue;
            end
            if (prev_setup) chk("setup_to_access", {PSEL, PENABLE}, 2'b11);
            prev_setup = 0;
            if (PSEL && !PENABLE) begin
                prev_setup = 1;
                cap = {PADDR, PWRITE, PWDATA, PSTRB};
                if (!PWRITE && seen_read) chk("poll_gap", cyc_g - last_rd, PG + 1);
                if (PWRITE && wait_word >= 0 && PADDR == 10'(IMG_BASE + wait_word))
                    wl = wait_n;
                else
                    wl = $urandom_range(0, wait_max);
            end else if (PSEL && PENABLE) begin
                if (wl > 0) begin
                    wl--;
                end else begin
                    PREADY = 1'b1;
                    chk("stable", {PADDR, PWRITE, PWDATA, PSTRB}, cap);
                    log_q.push_back(cap);
                    if (PWRITE) begin
                        PRDATA = $urandom;
                        PSLVERR = (err_word >= 0 && PADDR == 10'(IMG_BASE + err_word));
                    end else begin
                        PRDATA = (rd_k < n_inv) ? ($urandom & 32'h7FFF_FFFF) : res_val;
                        rd_k++;
                        seen_read = 1;
                        last_rd = cyc_g;
                    end
                end
            end
        end
    end

    task automatic run_frame(input bit seq, input int gmin, input int gmax,
                             input int wmax, input int wword, input int wn,
                             input int ninv, input int eword, input bit chk_lat);
        logic [31:0] w[$];
        logic [31:0] rv;
        bit e_err;
        int nrd;
        wait_max = wmax; wait_word = wword; wait_n = wn;
        n_inv = ninv; err_word = eword;
        rv = seq ? 32'h8000_0007 : ($urandom | 32'h8000_0000);
        res_val = rv;
        rd_k = 0; seen_read = 0;
        log_q.delete(); exp_q.delete();
        for (int i = 0; i < NW; i++) w.push_back(seq ? 32'(i) : $urandom);
        // reference: the bus transactions the frame should produce
        e_err = 0;
        for (int i = 0; i < NW && !e_err; i++) begin
            exp_q.push_back({10'(IMG_BASE + i), 1'b1, w[i], 4'hF});
            if (i == eword) e_err = 1;
        end
        if (!e_err) begin
            exp_q.push_back({10'(CMD), 1'b1, 32'h1, 4'hF});
            nrd = ninv + 1;
`ifdef APB_LOADER_POLL_TIMEOUT_EN
            if (nrd > MP) begin
                nrd = MP;
                e_err = 1;
            end
`endif
            for (int i = 0; i < nrd; i++)
                exp_q.push_back({10'(RES), 1'b0, 32'h0, 4'h0});
            if (!e_err) exp_result = rv;
        end
        frame_over = 0;
        start = 1'b1;
        @(posedge PCLK); #1;
        start = 1'b0;
        fork
            begin
                for (int i = 0; i < NW && !frame_over; i++) begin
                    int g;
                    bit acc;
                    g = $urandom_range(gmin, gmax);
                    repeat (g) begin @(posedge PCLK); #1; end
                    s_valid = 1'b1;
                    s_data = w[i];
                    acc = 0;
                    while (!acc && !frame_over) begin
                        @(negedge PCLK);
                        if (s_ready) begin
                            acc = 1;
                            chk("psel_in_wait", PSEL, 0);
                        end
                        @(posedge PCLK); #1;
                    end
                    s_valid = 1'b0;
                end
            end
            begin
                int cyc;
                bit got;
                cyc = 1; got = 0;
                while (!got && cyc < LIMIT) begin
                    @(negedge PCLK);
                    if (cyc == 10) start = 1'b1;
                    if (cyc == 11) start = 1'b0;
                    if (done) got = 1;
                    else cyc++;
                end
                frame_over = 1;
                start = 1'b0;
                chk("done_seen", got, 1);
                if (got) begin
                    if (chk_lat) chk("latency", cyc, 3 * NW + 5);
                    chk("busy_at_done", busy, 0);
                    @(negedge PCLK);
                    chk("done_pulse", done, 0);
                end
            end
        join
        s_valid = 1'b0;
        chk("err", err, e_err);
        chk("result", result, exp_result);
        chk("xact_cnt", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk("xact", log_q[i], exp_q[i]);
    endtask

    initial begin
        PRESETn = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
        wait_max = 0; wait_word = -1; wait_n = 0; n_inv = 0;
        err_word = -1; rd_k = 0; last_rd = 0; seen_read = 0;
        frame_over = 0; exp_result = '0;
        @(negedge PCLK);
        chk("rst_apb", {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB}, 0);
        chk("rst_ctrl", {s_ready, busy, done, err, result}, 0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;

        run_frame(1, 0, 0, 0, -1, 0, 0, -1, 1);
        run_frame(0, 0, 0, 0, 5, 3, 1, -1, 0);
        run_frame(0, 10, 10, 0, -1, 0, 0, -1, 0);
        run_frame(0, 0, 0, 0, -1, 0, 3, -1, 0);
        run_frame(0, 0, 2, 1, -1, 0, 0, 12, 0);
        for (int k = 0; k < 3; k++)
            run_frame(0, 0, 3, 2, -1, 0, $urandom_range(0, 3), -1, 0);

        // reset in the middle of the load phase
        start = 1'b1;
        @(posedge PCLK); #1;
        start = 1'b0;
        s_valid = 1'b1;
        s_data = $urandom;
        repeat (20) @(posedge PCLK);
        #1 PRESETn = 1'b0;
        #2;
        chk("rst_mid_apb", {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB}, 0);
        chk("rst_mid_ctrl", {s_ready, busy, done, err, result}, 0);
        s_valid = 1'b0;
        exp_result = '0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;
        run_frame(0, 0, 1, 1, -1, 0, 2, -1, 0);

`ifdef APB_LOADER_POLL_TIMEOUT_EN
        run_frame(0, 0, 0, 1, -1, 0, 1000, -1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
